// File: rtl/sll_req_arbiter.sv
// Round-robin arbiter that shares one singly-linked-list engine among NUM_REQ requesters,
// sequencing op_start/op_done and returning each result to its winner with a hung-engine watchdog.
module sll_req_arbiter #(
    parameter int  NUM_REQ        = 4,
    parameter int  DATA_WIDTH     = 8,
    parameter int  MAX_NODE       = 8,
    parameter int  TIMEOUT_CYCLES = 64,
    localparam int ADDR_WIDTH     = $clog2(MAX_NODE + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [3*NUM_REQ-1:0]             req_op,
    input  logic [DATA_WIDTH*NUM_REQ-1:0]    req_data,
    input  logic [ADDR_WIDTH*NUM_REQ-1:0]    req_addr,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_data,
    output logic [ADDR_WIDTH-1:0]            rsp_next_addr,
    output logic                             rsp_fault,
    output logic                             rsp_timeout,
    output logic                             busy,
    output logic                             ll_op_start,
    output logic [2:0]                       ll_op,
    output logic [DATA_WIDTH-1:0]            ll_data_in,
    output logic [ADDR_WIDTH-1:0]            ll_addr_in,
    input  logic                             ll_op_done,
    input  logic [DATA_WIDTH-1:0]            ll_data_out,
    input  logic [ADDR_WIDTH-1:0]            ll_next_node_addr,
    input  logic                             ll_fault
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]            state;
    logic                  timed_out;
    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       win_id;
    logic [WD_W-1:0]       wd_cnt;
    logic [2:0]            drain_cnt;
    logic [2:0]            lat_op;
    logic [DATA_WIDTH-1:0] lat_data;
    logic [ADDR_WIDTH-1:0] lat_addr;

    logic                  arb_found;
    logic [ID_W-1:0]       arb_idx;
    logic [ID_W-1:0]       arb_next;
    logic [2:0]            arb_op;
    logic [DATA_WIDTH-1:0] arb_data;
    logic [ADDR_WIDTH-1:0] arb_addr;
    logic                  arb_legal;
    logic [NUM_REQ-1:0]    arb_mask;
    logic [NUM_REQ-1:0]    win_mask;
    int                    cand;

    // Search upward from the round-robin pointer with wrap; first set request wins.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = rr_ptr;
        cand      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!arb_found && req_valid[cand]) begin
                arb_found = 1'b1;
                arb_idx   = ID_W'(cand);
            end
        end
    end

    always_comb begin
        arb_next  = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
        arb_op    = req_op[3*int'(arb_idx) +: 3];
        arb_data  = req_data[DATA_WIDTH*int'(arb_idx) +: DATA_WIDTH];
        arb_addr  = req_addr[ADDR_WIDTH*int'(arb_idx) +: ADDR_WIDTH];
        arb_legal = (arb_op != 3'd4) && (arb_op != 3'd6);
        arb_mask  = NUM_REQ'(1) << arb_idx;
        win_mask  = NUM_REQ'(1) << win_id;
    end

    assign busy       = (state != S_IDLE);
    assign ll_op      = lat_op;
    assign ll_data_in = lat_data;
    assign ll_addr_in = lat_addr;

    // Handshake: a requester holds req_valid and its fields until it sees its one-cycle
    // req_ready pulse; exactly one rsp_valid pulse follows for every accepted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            timed_out     <= 1'b0;
            rr_ptr        <= '0;
            win_id        <= '0;
            wd_cnt        <= '0;
            drain_cnt     <= '0;
            lat_op        <= '0;
            lat_data      <= '0;
            lat_addr      <= '0;
            req_ready     <= '0;
            rsp_valid     <= '0;
            rsp_data      <= '0;
            rsp_next_addr <= '0;
            rsp_fault     <= 1'b0;
            rsp_timeout   <= 1'b0;
            ll_op_start   <= 1'b0;
        end else begin
            req_ready   <= '0;
            rsp_valid   <= '0;
            rsp_fault   <= 1'b0;
            rsp_timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (arb_found) begin
                        lat_op    <= arb_op;
                        lat_data  <= arb_data;
                        lat_addr  <= arb_addr;
                        win_id    <= arb_idx;
                        rr_ptr    <= arb_next;
                        req_ready <= arb_mask;
                        timed_out <= 1'b0;
                        wd_cnt    <= '0;
                        if (arb_legal) begin
                            state       <= S_WAIT;
                            ll_op_start <= 1'b1;
                        end else begin
                            state     <= S_RESP;
                            rsp_valid <= arb_mask;
                            rsp_fault <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (ll_op_done) begin
                        state         <= S_RESP;
                        ll_op_start   <= 1'b0;
                        rsp_valid     <= win_mask;
                        rsp_data      <= ll_data_out;
                        rsp_next_addr <= ll_next_node_addr;
                        rsp_fault     <= ll_fault;
                    end else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        state       <= S_RESP;
                        ll_op_start <= 1'b0;
                        timed_out   <= 1'b1;
                        rsp_valid   <= win_mask;
                        rsp_fault   <= 1'b1;
                        rsp_timeout <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    // After a timeout the engine may still be mid-op; let it settle first.
                    state     <= timed_out ? S_DRAIN : S_IDLE;
                    drain_cnt <= '0;
                end
                default: begin
                    if (ll_op_done || drain_cnt == 3'd7) begin
                        state <= S_IDLE;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sll_req_arbiter.sv
// Directed bench for sll_req_arbiter: a small list-engine model behind the arbiter,
// expected grants and responses queued at issue time and checked by an independent monitor.
module tb_sll_req_arbiter;

    localparam int NR      = 4;
    localparam int DW      = 8;
    localparam int MN      = 8;
    localparam int AW      = 4;
    localparam int TO      = 8;
    localparam int ENG_LAT = 3;
    localparam logic [AW-1:0] NULL_ADDR = 4'd8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req_valid;
    logic [3*NR-1:0]   req_op;
    logic [DW*NR-1:0]  req_data;
    logic [AW*NR-1:0]  req_addr;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic [AW-1:0]     rsp_next_addr;
    logic              rsp_fault;
    logic              rsp_timeout;
    logic              busy;
    logic              ll_op_start;
    logic [2:0]        ll_op;
    logic [DW-1:0]     ll_data_in;
    logic [AW-1:0]     ll_addr_in;
    logic              ll_op_done;
    logic [DW-1:0]     ll_data_out;
    logic [AW-1:0]     ll_next_node_addr;
    logic              ll_fault;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int n_starts = 0;
    logic hang   = 1'b0;

    // exp_q: {onehot[18:15], check_data, data[13:6], next[5:2], fault, timeout}
    logic [18:0] exp_q[$];
    // gnt_q: {onehot[19:16], legal, op[14:12], data[11:4], addr[3:0]}
    logic [19:0] gnt_q[$];

    sll_req_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_NODE(MN), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_op(req_op), .req_data(req_data), .req_addr(req_addr),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_next_addr(rsp_next_addr), .rsp_fault(rsp_fault), .rsp_timeout(rsp_timeout),
        .busy(busy), .ll_op_start(ll_op_start), .ll_op(ll_op), .ll_data_in(ll_data_in),
        .ll_addr_in(ll_addr_in), .ll_op_done(ll_op_done), .ll_data_out(ll_data_out),
        .ll_next_node_addr(ll_next_node_addr), .ll_fault(ll_fault)
    );

    // ---------------- clock / reset ----------------
    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- list engine model ----------------
    // Storage grows by push_back only; reads fault past the last node, other ops fault on empty.
    logic [DW-1:0] mem_data[MN];
    logic [AW-1:0] mem_next[MN];
    int            n_nodes;
    int            eng_cnt;
    logic          eng_busy;
    logic [2:0]    e_op;
    logic [DW-1:0] e_data;
    logic [AW-1:0] e_addr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_busy          <= 1'b0;
            eng_cnt           <= 0;
            n_nodes           <= 0;
            e_op              <= '0;
            e_data            <= '0;
            e_addr            <= '0;
            ll_op_done        <= 1'b0;
            ll_fault          <= 1'b0;
            ll_data_out       <= '0;
            ll_next_node_addr <= '0;
        end else begin
            ll_op_done <= 1'b0;
            if (!eng_busy) begin
                if (ll_op_start && !ll_op_done && !hang) begin
                    eng_busy <= 1'b1;
                    eng_cnt  <= ENG_LAT;
                    e_op     <= ll_op;
                    e_data   <= ll_data_in;
                    e_addr   <= ll_addr_in;
                end
            end else if (eng_cnt > 0) begin
                eng_cnt <= eng_cnt - 1;
            end else begin
                eng_busy   <= 1'b0;
                ll_op_done <= 1'b1;
                case (e_op)
                    3'd0: begin
                        if (int'(e_addr) < n_nodes) begin
                            ll_data_out       <= mem_data[e_addr[2:0]];
                            ll_next_node_addr <= mem_next[e_addr[2:0]];
                            ll_fault          <= 1'b0;
                        end else begin
                            ll_fault <= 1'b1;
                        end
                    end
                    3'd1: begin
                        if (e_addr == NULL_ADDR && n_nodes < MN) begin
                            mem_data[3'(n_nodes)] <= e_data;
                            mem_next[3'(n_nodes)] <= NULL_ADDR;
                            if (n_nodes > 0) mem_next[3'(n_nodes - 1)] <= AW'(n_nodes);
                            n_nodes     <= n_nodes + 1;
                            ll_data_out <= e_data;
                            ll_fault    <= 1'b0;
                        end else begin
                            ll_fault <= 1'b1;
                        end
                    end
                    default: ll_fault <= (n_nodes == 0);
                endcase
            end
        end
    end

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    logic          m_prev_start = 1'b0;
    logic          m_prev_busy  = 1'b0;
    logic [14:0]   m_prev_cmd   = '0;
    logic          m_busy_pend  = 1'b0;
    int            m_wait_start = 0;
    int            m_rsp_cyc    = 0;
    int            m_idle_gap   = 0;
    logic [18:0]   m_e;
    logic [19:0]   m_g;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            m_prev_start = 1'b0;
            m_prev_busy  = 1'b0;
            m_busy_pend  = 1'b0;
        end else begin
            if (ll_op_start && !m_prev_start) begin
                m_wait_start = cyc;
                n_starts++;
            end
            if (ll_op_start && m_prev_start)
                chk("cmd_stable", 64'({ll_op, ll_data_in, ll_addr_in}), 64'(m_prev_cmd));
            if (req_ready != '0) begin
                if (gnt_q.size() == 0) begin
                    chk("unexpected_grant", 64'(req_ready), 64'(0));
                end else begin
                    m_g = gnt_q.pop_front();
                    chk("grant", 64'(req_ready), 64'(m_g[19:16]));
                    if (m_g[15])
                        chk("cmd", 64'({ll_op_start, ll_op, ll_data_in, ll_addr_in}),
                            64'({1'b1, m_g[14:0]}));
                    else
                        chk("illegal_no_start", 64'(ll_op_start), 64'(0));
                end
            end
            if (rsp_valid != '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 64'(rsp_valid), 64'(0));
                end else begin
                    m_e = exp_q.pop_front();
                    chk("rsp_valid", 64'(rsp_valid), 64'(m_e[18:15]));
                    chk("rsp_fault", 64'({rsp_fault, rsp_timeout}), 64'(m_e[1:0]));
                    chk("start_low_in_resp", 64'(ll_op_start), 64'(0));
                    if (m_e[14])
                        chk("rsp_data", 64'({rsp_data, rsp_next_addr}), 64'(m_e[13:2]));
                    if (m_e[0])
                        chk("timeout_latency", 64'(cyc - m_wait_start), 64'(TO));
                    m_busy_pend = 1'b1;
                    m_rsp_cyc   = cyc;
                    m_idle_gap  = m_e[0] ? 9 : 1;
                end
            end
            if (m_prev_busy && !busy && m_busy_pend) begin
                chk("idle_gap", 64'(cyc - m_rsp_cyc), 64'(m_idle_gap));
                m_busy_pend = 1'b0;
            end
            m_prev_start = ll_op_start;
            m_prev_busy  = busy;
            m_prev_cmd   = {ll_op, ll_data_in, ll_addr_in};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input int id, input logic [2:0] op, input logic [DW-1:0] d,
                         input logic [AW-1:0] a, input logic legal);
        logic [NR-1:0] oh;
        oh = NR'(1) << id;
        req_op[3*id +: 3]     = op;
        req_data[DW*id +: DW] = d;
        req_addr[AW*id +: AW] = a;
        req_valid[id]         = 1'b1;
        gnt_q.push_back({oh, legal, op, d, a});
    endtask

    task automatic push_rsp(input int id, input logic chk_d, input logic [DW-1:0] d,
                            input logic [AW-1:0] nx, input logic f, input logic t);
        logic [NR-1:0] oh;
        oh = NR'(1) << id;
        exp_q.push_back({oh, chk_d, d, nx, f, t});
    endtask

    task automatic serve(input int budget);
        int n;
        n = 0;
        while ((req_valid != '0 || busy || exp_q.size() != 0 || gnt_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
            for (int i = 0; i < NR; i++)
                if (req_ready[i]) req_valid[i] = 1'b0;
        end
        chk("serve_budget", 64'(n < budget), 64'(1));
        if (n >= budget) begin
            req_valid = '0;
            exp_q.delete();
            gnt_q.delete();
        end
    endtask

    // ---------------- global bound ----------------
    initial begin
        #200000;
        n_errors++;
        $display("FAIL global_timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int s;
        req_valid = '0;
        req_op    = '0;
        req_data  = '0;
        req_addr  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 64'({req_ready, rsp_valid, rsp_data, rsp_next_addr, rsp_fault,
                                  rsp_timeout, busy, ll_op_start, ll_op, ll_data_in, ll_addr_in}), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // delete value on an empty list: engine fault
        issue(0, 3'd2, 8'h11, 4'd0, 1'b1);
        push_rsp(0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0);
        serve(200);

        // requester 1: push_back 0x5A, then read node 0
        issue(1, 3'd1, 8'h5A, NULL_ADDR, 1'b1);
        push_rsp(1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        serve(200);
        issue(1, 3'd0, 8'h00, 4'd0, 1'b1);
        push_rsp(1, 1'b1, 8'h5A, NULL_ADDR, 1'b0, 1'b0);
        serve(200);

        // requesters 0,2,3 together with pointer at 2: order 2, 3, 0
        issue(2, 3'd0, 8'h00, 4'd0, 1'b1);
        issue(3, 3'd0, 8'h00, 4'd5, 1'b1);
        issue(0, 3'd0, 8'h00, 4'd0, 1'b1);
        push_rsp(2, 1'b1, 8'h5A, NULL_ADDR, 1'b0, 1'b0);
        push_rsp(3, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0);
        push_rsp(0, 1'b1, 8'h5A, NULL_ADDR, 1'b0, 1'b0);
        serve(300);

        // illegal opcode 4: local reject, engine never started
        s = n_starts;
        issue(0, 3'd4, 8'hAA, 4'd3, 1'b0);
        push_rsp(0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0);
        serve(200);
        chk("illegal_start_count", 64'(n_starts), 64'(s));

        // hung engine: watchdog, drain, then a normal op
        hang = 1'b1;
        issue(2, 3'd0, 8'h00, 4'd0, 1'b1);
        push_rsp(2, 1'b0, 8'h00, 4'd0, 1'b1, 1'b1);
        serve(200);
        hang = 1'b0;
        issue(3, 3'd0, 8'h00, 4'd0, 1'b1);
        push_rsp(3, 1'b1, 8'h5A, NULL_ADDR, 1'b0, 1'b0);
        serve(200);

        // async reset in the middle of WAIT
        issue(1, 3'd0, 8'h00, 4'd0, 1'b1);
        n = 0;
        while (!ll_op_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", 64'(n < 50), 64'(1));
        req_valid[1] = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("reset_mid_wait", 64'({req_ready, rsp_valid, rsp_data, rsp_next_addr, rsp_fault,
                                   rsp_timeout, busy, ll_op_start, ll_op, ll_data_in, ll_addr_in}), 64'(0));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // pointer back at 0 and list emptied by the shared reset
        issue(0, 3'd0, 8'h00, 4'd0, 1'b1);
        issue(3, 3'd1, 8'h33, NULL_ADDR, 1'b1);
        push_rsp(0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0);
        push_rsp(3, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        serve(300);

        repeat (3) @(negedge clk);
        chk("queues_drained", 64'(exp_q.size() + gnt_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sll_req_arbiter.md
Name: sll_req_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one singly-linked-list engine among NUM_REQ requesters.
- Latches the winning request and drives the engine's op/op_start handshake, holding all command fields stable until op_done.
- Routes the engine result back to the winner as a one-cycle response, with a watchdog for a hung engine.
- Sits between client blocks and the list engine instance.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- DATA_WIDTH, 8, list data width.
- MAX_NODE, 8, list capacity.
- ADDR_WIDTH, $clog2(MAX_NODE+1), localparam, not overridable. Address MAX_NODE = NULL.
- TIMEOUT_CYCLES, 64, max WAIT cycles before abort (≥8).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  NUM_REQ  per-requester request
- req_op  in  3*NUM_REQ  per-requester opcode, slice i = [3i+2:3i]
- req_data  in  DATA_WIDTH*NUM_REQ  per-requester data
- req_addr  in  ADDR_WIDTH*NUM_REQ  per-requester addr/index
- req_ready  out  NUM_REQ  one-hot, 1-cycle pulse: request accepted
- rsp_valid  out  NUM_REQ  one-hot, 1-cycle pulse: response for requester i
- rsp_data  out  DATA_WIDTH  read data
- rsp_next_addr  out  ADDR_WIDTH  read next-node addr
- rsp_fault  out  1  op faulted (engine fault, local reject or timeout)
- rsp_timeout  out  1  fault caused by watchdog
- busy  out  1  state != IDLE
- ll_op_start  out  1  to engine op_start
- ll_op  out  3  to engine op
- ll_data_in  out  DATA_WIDTH  to engine data_in
- ll_addr_in  out  ADDR_WIDTH  to engine addr_in
- ll_op_done  in  1  from engine
- ll_data_out  in  DATA_WIDTH  from engine
- ll_next_node_addr  in  ADDR_WIDTH  from engine
- ll_fault  in  1  from engine

Behaviour:
- Reset values: all outputs 0. RR pointer = 0. State IDLE. Watchdog count = 0.
- Reset mid-operation aborts with no response. The engine is reset by the same rst.
- Legal opcodes: 0 read, 1 insert@addr, 2 delete value, 3 delete@addr, 5 insert@index, 7 delete@index. Opcodes 4 and 6 are rejected locally.
- States: IDLE, WAIT, RESP, DRAIN.
- IDLE, any req_valid:
  - Winner = first set bit at or after RR pointer, searching upward with wrap.
  - Latch winner's op/data/addr and winner id. RR pointer := winner+1 mod NUM_REQ.
  - Legal op: next cycle WAIT, with ll_op_start=1 and req_ready[winner]=1 for that one cycle.
  - Illegal op: next cycle RESP with rsp_fault=1, req_ready pulse in the same cycle, ll_op_start never asserted.
  - Requester holds its fields until req_ready. Fields are don't-care afterwards.
- WAIT:
  - ll_op_start=1; ll_op/data/addr driven from latched regs, constant.
  - On a clk edge with ll_op_done=1: capture ll_data_out, ll_next_node_addr, ll_fault; go to RESP.
  - ll_op_start is low in RESP. It is registered, so the engine never sees op_start high in its IDLE after done.
- RESP: one cycle. rsp_valid[winner]=1 and rsp_* valid. Next state IDLE.
- Minimum throughput: one op per (engine latency + 3) cycles. A new request is never sampled in RESP.
- Watchdog:
  - Counts WAIT cycles.
  - On reaching TIMEOUT_CYCLES without done: drop ll_op_start, go to RESP with rsp_fault=1, rsp_timeout=1.
  - Then go to DRAIN instead of IDLE.
- DRAIN:
  - ll_op_start=0.
  - Exit to IDLE when ll_op_done seen, or after 8 cycles, whichever comes first.
  - Any done pulse in DRAIN is discarded.
- rsp_data/rsp_next_addr hold their last value outside RESP. On write ops they carry whatever the engine output (don't-care).
- Simultaneous requests: exactly one grant per arbitration. Losers keep req_valid high and win in RR order.
- A requester that drops req_valid before req_ready loses the slot without a response.

Test Plan:
- Reset asserted mid-WAIT (async, between edges) -> all outputs 0 immediately, no rsp_valid after release, next arbitration starts at requester 0.
- Requester 1 inserts data 0x5A at addr 8 (NULL, push_back), then reads addr 0 -> two req_ready pulses on bit1; read rsp_data=0x5A, rsp_next_addr=8, rsp_fault=0; ll_op_start high through the done cycle, low in RESP.
- Requesters 0, 2, 3 assert together with reads, RR pointer=2 -> grant order 2, 3, 0; each rsp_valid one-hot to the matching bit; no overlap of ll_op_start between ops.
- Requester 0 issues op=4 -> req_ready[0] and rsp_valid[0] with rsp_fault=1, rsp_timeout=0; ll_op_start stays 0 throughout.
- Engine stubbed to never assert done, TIMEOUT_CYCLES=8 -> rsp_fault=1, rsp_timeout=1 exactly 8 cycles after WAIT entry; DRAIN lasts 8 cycles; next request served normally.
- Delete value on empty list -> engine faults; rsp_fault=1, rsp_timeout=0, busy returns to 0 one cycle after RESP.
